exe: RTL and testbench

//  Execute stage of a small 10-bit datapath: 16x10-bit register file plus a combinational ALU.
//  Two read ports feed the ALU; operand B comes from the register file or from the immediate input.
//  One synchronous write port updates the register file.
//  The ALU result and flags drive the stage outputs combinationally.

---
 rtl/exe.sv | 159 +++++++++++++++
 tb/tb_exe.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe.sv
//==============================================================================
// Module      : exe
// Description : Execute stage of a 10-bit datapath. A 16 x 10-bit register
//               file (R0 hard-wired to zero) feeds a combinational ALU.
//               Operand B is taken from the register file or from the
//               immediate input. One synchronous write port.
//
// Ports       : i_clk    - clock, rising edge active
//               i_rsn    - asynchronous active-low reset (clears R1..R15)
//               i_oper   - ALU opcode (ADD/SUB/SHIFT/AND/ORR/XOR/XNOR/MOVB)
//               i_reg0   - read address, operand A
//               i_reg1   - read address, operand B (when i_imm = 0)
//               i_reg2   - write address, 0 disables the write
//               i_data2  - write data
//               i_data   - immediate operand B
//               i_imm    - 1 selects i_data as operand B
//               o_data   - ALU result (combinational)
//               o_flag   - {N, Z, C, V} (combinational)
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module exe #(
    parameter int DW = 10,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rsn,
    input  logic [2:0]    i_oper,
    input  logic [AW-1:0] i_reg0,
    input  logic [AW-1:0] i_reg1,
    input  logic [AW-1:0] i_reg2,
    input  logic [DW-1:0] i_data2,
    input  logic [DW-1:0] i_data,
    input  logic          i_imm,
    output logic [DW-1:0] o_data,
    output logic [3:0]    o_flag
);

    localparam int        c_NREG = 1 << AW;

    localparam logic [2:0] c_OP_ADD   = 3'd0;
    localparam logic [2:0] c_OP_SUB   = 3'd1;
    localparam logic [2:0] c_OP_SHIFT = 3'd2;
    localparam logic [2:0] c_OP_AND   = 3'd3;
    localparam logic [2:0] c_OP_ORR   = 3'd4;
    localparam logic [2:0] c_OP_XOR   = 3'd5;
    localparam logic [2:0] c_OP_XNOR  = 3'd6;
    localparam logic [2:0] c_OP_MOVB  = 3'd7;

    // Shift amounts at or beyond DW+1 behave identically (everything shifted
    // out, carry is fill bit), so the amount is saturated to DW+1.
    localparam int         c_SAT  = DW + 1;
    localparam int         c_SHW  = $clog2(c_SAT + 1);
    localparam int         c_EXTW = 2 * DW + 1;

    //--------------------------------------------------------------------------
    // Register file
    //--------------------------------------------------------------------------
    logic [DW-1:0] w_rf [0:c_NREG-1];

    assign w_rf[0] = '0;

    genvar k;
    generate
        for (k = 1; k < c_NREG; k++) begin : g_reg
            logic [DW-1:0] r_reg;

            always_ff @(posedge i_clk or negedge i_rsn) begin
                if (!i_rsn) begin
                    r_reg <= '0;
                end else if (i_reg2 == AW'(k)) begin
                    r_reg <= i_data2;
                end
            end

            assign w_rf[k] = r_reg;
        end
    endgenerate

    // Asynchronous reads, no bypass: the written value appears after the edge.
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;

    assign w_a = w_rf[i_reg0];
    assign w_b = i_imm ? i_data : w_rf[i_reg1];

    //--------------------------------------------------------------------------
    // Shifter: B >= 0 shifts left, B < 0 shifts right arithmetically by -B
    //--------------------------------------------------------------------------
    logic                    w_b_neg;
    logic [DW-1:0]           w_amt_raw;
    logic [c_SHW-1:0]        w_amt;
    logic [c_EXTW-1:0]       w_shl;
    logic signed [c_EXTW-1:0] w_shr;

    assign w_b_neg   = w_b[DW-1];
    // Two's complement negate; -(-2^(DW-1)) is still correct read as unsigned.
    assign w_amt_raw = w_b_neg ? (~w_b + DW'(1)) : w_b;
    assign w_amt     = (w_amt_raw >= DW'(c_SAT)) ? c_SHW'(c_SAT) : w_amt_raw[c_SHW-1:0];

    // Left: the bit just above the result window is the last bit shifted out.
    assign w_shl = {{(DW + 1){1'b0}}, w_a} << w_amt;
    // Right: A sits in the top of the word; the bit just below the window is
    // the last bit shifted out (sign once everything has been shifted out).
    assign w_shr = $signed({w_a, {(DW + 1){1'b0}}}) >>> w_amt;

    //--------------------------------------------------------------------------
    // ALU
    //--------------------------------------------------------------------------
    logic [DW:0]   w_sum;
    logic [DW:0]   w_dif;
    logic [DW-1:0] w_res;
    logic          w_c;
    logic          w_v;

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};
    assign w_dif = {1'b0, w_a} - {1'b0, w_b};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (i_oper)
            c_OP_ADD: begin
                w_res = w_sum[DW-1:0];
                w_c   = w_sum[DW];
                w_v   = (w_a[DW-1] == w_b[DW-1]) && (w_sum[DW-1] != w_a[DW-1]);
            end
            c_OP_SUB: begin
                w_res = w_dif[DW-1:0];
                w_c   = ~w_dif[DW];   // carry = no borrow
                w_v   = (w_a[DW-1] != w_b[DW-1]) && (w_dif[DW-1] != w_a[DW-1]);
            end
            c_OP_SHIFT: begin
                if (w_b_neg) begin
                    w_res = w_shr[c_EXTW-1 -: DW];
                    w_c   = w_shr[DW];
                end else begin
                    w_res = w_shl[DW-1:0];
                    w_c   = w_shl[DW];
                end
            end
            c_OP_AND:  w_res = w_a & w_b;
            c_OP_ORR:  w_res = w_a | w_b;
            c_OP_XOR:  w_res = w_a ^ w_b;
            c_OP_XNOR: w_res = ~(w_a ^ w_b);
            c_OP_MOVB: w_res = w_b;
            default:   w_res = '0;
        endcase
    end

    assign o_data = w_res;
    assign o_flag = {w_res[DW-1], (w_res == '0), w_c, w_v};

endmodule

`default_nettype wire

// File: tb/tb_exe.sv
//==============================================================================
// Module      : tb_exe
// Description : Self-checking bench for exe. Directed scenarios plus a
//               randomized run against an arithmetic reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_exe;

    localparam logic [2:0] c_ADD = 3'd0, c_SUB = 3'd1, c_SHIFT = 3'd2, c_AND = 3'd3,
                           c_ORR = 3'd4, c_XOR = 3'd5, c_XNOR = 3'd6, c_MOVB = 3'd7;

    logic       i_clk = 1'b0;
    logic       i_rsn = 1'b0;
    logic [2:0] i_oper = '0;
    logic [3:0] i_reg0 = '0, i_reg1 = '0, i_reg2 = '0;
    logic [9:0] i_data2 = '0, i_data = '0;
    logic       i_imm = 1'b0;
    logic [9:0] o_data;
    logic [3:0] o_flag;

    int checks   = 0;
    int failures = 0;

    // Reference register contents as plain integers 0..1023
    int mdl [16];

    exe u_dut (
        .i_clk  (i_clk),
        .i_rsn  (i_rsn),
        .i_oper (i_oper),
        .i_reg0 (i_reg0),
        .i_reg1 (i_reg1),
        .i_reg2 (i_reg2),
        .i_data2(i_data2),
        .i_data (i_data),
        .i_imm  (i_imm),
        .o_data (o_data),
        .o_flag (o_flag)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            for (int j = 0; j < 16; j++) mdl[j] = 0;
        end else if (i_reg2 != 4'd0) begin
            mdl[i_reg2] = int'(i_data2);
        end
    end

    function automatic int to_s(input int u);
        return (u >= 512) ? u - 1024 : u;
    endfunction

    // Reference ALU from the arithmetic definition of each operation.
    function automatic void ref_alu(input int op, input int au, input int bu,
                                    output int res, output logic [3:0] fl);
        int as, bs, t, n;
        logic c, v;
        as = to_s(au);
        bs = to_s(bu);
        c = 1'b0;
        v = 1'b0;
        res = 0;
        case (op)
            0: begin
                t = au + bu; res = t % 1024; c = (t >= 1024);
                t = as + bs; v = (t > 511) || (t < -512);
            end
            1: begin
                res = (au - bu + 1024) % 1024; c = (au >= bu);
                t = as - bs; v = (t > 511) || (t < -512);
            end
            2: begin
                if (bs >= 0) begin
                    n = bs;
                    if (n == 0) res = au;
                    else if (n <= 10) begin
                        res = (au << n) % 1024;
                        c   = ((au >> (10 - n)) & 1) != 0;
                    end else res = 0;
                end else begin
                    n = -bs;
                    if (n <= 10) begin
                        res = (as >>> n) & 1023;
                        c   = ((as >>> (n - 1)) & 1) != 0;
                    end else begin
                        res = (as < 0) ? 1023 : 0;
                        c   = (as < 0);
                    end
                end
            end
            3: res = au & bu;
            4: res = au | bu;
            5: res = au ^ bu;
            6: res = (~(au ^ bu)) & 1023;
            default: res = bu;
        endcase
        fl = {(res >= 512), (res == 0), c, v};
    endfunction

    task automatic drive(input logic [2:0] op, input int r0, input int r1, input int r2,
                         input int d2, input int dat, input logic imm);
        i_oper  = op;
        i_reg0  = 4'(r0);
        i_reg1  = 4'(r1);
        i_reg2  = 4'(r2);
        i_data2 = 10'(d2);
        i_data  = 10'(dat);
        i_imm   = imm;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        i_rsn = 1'b0;
        #2;
        for (int r = 1; r < 16; r++) begin
            drive(c_MOVB, 0, r, 0, 0, 0, 1'b0);
            #1;
            checks++;
            if (o_data !== 10'd0 || o_flag !== 4'b0100) begin
                failures++;
                $display("FAIL reset_R%0d data=%0d flag=%b want 0 0100", r, o_data, o_flag);
            end
        end
        next_cycle();
        i_rsn = 1'b1;
        next_cycle();
    endtask

    task automatic test_load_ops();
        logic [2:0] ops [6];
        int ra [6], rb [6];
        logic [9:0] ed [6];
        logic [3:0] ef [6];
        for (int k = 1; k <= 9; k++) begin
            drive(c_MOVB, 0, 0, k, 24 * k, 0, 1'b0);
            next_cycle();
        end
        ops = '{c_MOVB, c_ADD, c_SUB, c_AND, c_XOR, c_XNOR};
        ra  = '{0, 1, 2, 4, 6, 7};
        rb  = '{9, 2, 3, 5, 7, 8};
        ed  = '{10'd216, 10'd72, 10'd1000, 10'd96, 10'd56, 10'd919};
        ef  = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b1000};
        for (int t = 0; t < 6; t++) begin
            drive(ops[t], ra[t], rb[t], 0, 0, 0, 1'b0);
            #1;
            checks++;
            if (o_data !== ed[t] || o_flag !== ef[t]) begin
                failures++;
                $display("FAIL op%0d_R%0d_R%0d data=%0d flag=%b want %0d %b",
                         ops[t], ra[t], rb[t], o_data, o_flag, ed[t], ef[t]);
            end
        end
    endtask

    task automatic test_feedback();
        drive(c_ADD, 7, 8, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd360 || o_flag !== 4'b0000) begin
            failures++;
            $display("FAIL add_R7_R8 data=%0d flag=%b want 360 0000", o_data, o_flag);
        end
        // Feed the result back into R9 while reading R9: old value until the edge
        drive(c_ADD, 9, 6, 9, int'(o_data), 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd360) begin
            failures++;
            $display("FAIL no_bypass data=%0d want 360", o_data);
        end
        next_cycle();
        drive(c_ADD, 9, 6, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd504 || o_flag !== 4'b0000) begin
            failures++;
            $display("FAIL add_R9_R6 data=%0d flag=%b want 504 0000", o_data, o_flag);
        end
        drive(c_ADD, 9, 8, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd552 || o_flag !== 4'b1001) begin
            failures++;
            $display("FAIL add_wrap data=%0d flag=%b want 552 1001", o_data, o_flag);
        end
        drive(c_SUB, 4, 1, 0, 0, 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd72 || o_flag !== 4'b0010) begin
            failures++;
            $display("FAIL sub_R4_R1 data=%0d flag=%b want 72 0010", o_data, o_flag);
        end
        i_reg2  = 4'd4;
        i_data2 = o_data;
        next_cycle();
        drive(c_MOVB, 0, 4, 0, 123, 0, 1'b0);
        #1;
        checks++;
        if (o_data !== 10'd72) begin
            failures++;
            $display("FAIL read_R4 data=%0d want 72", o_data);
        end
        // Address 0 write must be discarded
        drive(c_MOVB, 0, 0, 0, 123, 0, 1'b0);
        next_cycle();
        #1;
        checks++;
        if (o_data !== 10'd0 || o_flag !== 4'b0100) begin
            failures++;
            $display("FAIL r0_zero data=%0d flag=%b want 0 0100", o_data, o_flag);
        end
    endtask

    task automatic test_immediate();
        drive(c_ADD, 0, 9, 0, 0, 27, 1'b1);
        #1;
        checks++;
        if (o_data !== 10'd27 || o_flag !== 4'b0000) begin
            failures++;
            $display("FAIL imm_add data=%0d flag=%b want 27 0000", o_data, o_flag);
        end
        drive(c_SHIFT, 1, 0, 0, 0, -2, 1'b1);
        #1;
        checks++;
        if (o_data !== 10'd6 || o_flag !== 4'b0000) begin
            failures++;
            $display("FAIL shr2 data=%0d flag=%b want 6 0000", o_data, o_flag);
        end
        drive(c_SHIFT, 1, 0, 0, 0, 3, 1'b1);
        #1;
        checks++;
        if (o_data !== 10'd192 || o_flag !== 4'b0000) begin
            failures++;
            $display("FAIL shl3 data=%0d flag=%b want 192 0000", o_data, o_flag);
        end
    endtask

    task automatic test_reset_mid();
        #2;                     // mid-cycle, away from any edge
        i_rsn = 1'b0;
        for (int r = 1; r <= 9; r++) begin
            drive(c_MOVB, 0, r, 0, 0, 0, 1'b0);
            #1;
            checks++;
            if (o_data !== 10'd0) begin
                failures++;
                $display("FAIL midreset_R%0d data=%0d want 0", r, o_data);
            end
        end
        drive(c_ADD, 1, 0, 3, 77, 5, 1'b1);
        #1;
        checks++;
        if (o_data !== 10'd5) begin
            failures++;
            $display("FAIL midreset_imm data=%0d want 5", o_data);
        end
        next_cycle();           // write attempted while in reset
        drive(c_MOVB, 0, 3, 0, 0, 0, 1'b0);
        #1;
        i_rsn = 1'b1;
        #1;
        checks++;
        if (o_data !== 10'd0) begin
            failures++;
            $display("FAIL reset_write_ignored data=%0d want 0", o_data);
        end
        next_cycle();
    endtask

    task automatic test_random();
        int au, bu, er;
        logic [3:0] ef;
        logic [2:0] op;
        int r0, r1, r2, dat;
        logic imm;
        for (int it = 0; it < 400; it++) begin
            op  = 3'($urandom_range(0, 7));
            r0  = $urandom_range(0, 15);
            r1  = $urandom_range(0, 15);
            r2  = $urandom_range(0, 15);
            imm = 1'($urandom_range(0, 1));
            // Bias shift immediates toward small and saturating amounts
            if (op == c_SHIFT && imm && $urandom_range(0, 1) == 1)
                dat = ($urandom_range(0, 24) - 12) & 1023;
            else
                dat = $urandom_range(0, 1023);
            drive(op, r0, r1, r2, $urandom_range(0, 1023), dat, imm);
            au = mdl[r0];
            bu = imm ? dat : mdl[r1];
            ref_alu(int'(op), au, bu, er, ef);
            #1;
            checks++;
            if (o_data !== 10'(er) || o_flag !== ef) begin
                failures++;
                $display("FAIL rand%0d op=%0d a=%0d b=%0d data=%0d flag=%b want %0d %b",
                         it, op, au, bu, o_data, o_flag, er, ef);
            end
            if ($urandom_range(0, 3) == 0) i_data2 = 10'(er);
            next_cycle();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_load_ops();
        test_feedback();
        test_immediate();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
